// File: rtl/instr_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue_pkg
// Description : Shared default sizes and opcode type for the instruction queue
// Revision    : 1.0 - initial release
// ============================================================================
package instr_queue_pkg;

    localparam int IQ_WIDTH = 16;
    localparam int IQ_DEPTH = 4;
    localparam int IQ_OPW   = 4;

    typedef logic [IQ_OPW-1:0] opcode_t;

endpackage : instr_queue_pkg
`default_nettype wire

// File: rtl/instr_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue_mem
// Description : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous read port; contents are not reset
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue_mem
    import instr_queue_pkg::*;
#(
    parameter int WIDTH = IQ_WIDTH,
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(IQ_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : instr_queue_mem
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : Instruction FIFO with flush, sticky overrun flag and masked
//               head outputs
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int WIDTH = IQ_WIDTH,
    parameter int DEPTH = IQ_DEPTH,
    parameter int OPW   = IQ_OPW
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Load,
    input  logic [WIDTH-1:0]       Data,
    input  logic                   Advance,
    input  logic                   Flush,
    output logic                   Ready,
    output logic                   Valid,
    output logic [WIDTH-1:0]       Instruction,
    output logic [OPW-1:0]         Opcode,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overrun
);

    localparam int                 c_AW    = $clog2(DEPTH);
    localparam int                 c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0]    c_FULL  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]    c_CONE  = c_CW'(1);
    localparam logic [c_AW-1:0]    c_PONE  = c_AW'(1);

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overrun;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Flags come straight from the count register so reset clears them at once
    assign Ready = (r_count != c_FULL);
    assign Valid = (r_count != '0);

    // Flush wins over both requests; a full-queue push is rejected by Ready
    assign w_push = Load    && Ready && !Flush;
    assign w_pop  = Advance && Valid && !Flush;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (Flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CONE;
            end
            if (Load && !Ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    instr_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .i_clk   (Clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (Data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Stale storage must never leak out while the queue is empty
    assign Instruction = Valid ? w_head : '0;
    assign Opcode      = Instruction[WIDTH-1 -: OPW];
    assign Count       = r_count;
    assign Overrun     = r_overrun;

endmodule : instr_queue
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Self-checking bench: vector table plus retire-order scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int c_DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Data = '0;
    logic        Advance = 1'b0;
    logic        Flush = 1'b0;
    logic        Ready;
    logic        Valid;
    logic [15:0] Instruction;
    opcode_t     Opcode;
    logic [2:0]  Count;
    logic        Overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] sb[$];

    instr_queue #(.WIDTH(16), .DEPTH(c_DEPTH), .OPW(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Load        (Load),
        .Data        (Data),
        .Advance     (Advance),
        .Flush       (Flush),
        .Ready       (Ready),
        .Valid       (Valid),
        .Instruction (Instruction),
        .Opcode      (Opcode),
        .Count       (Count),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        ld;
        logic [15:0] data;
        logic        adv;
        logic        fl;
        int          ecount;
        logic [15:0] einstr;
        logic        eov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; retirements are checked against the scoreboard head
    task automatic step(input logic ld, input logic [15:0] d, input logic adv, input logic fl);
        bit pushed;
        @(negedge Clk);
        Load = ld; Data = d; Advance = adv; Flush = fl;
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            pushed = ld && (sb.size() < c_DEPTH);
            if (adv && sb.size() > 0) begin
                check("retire_order", 32'(Instruction), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (pushed) sb.push_back(d);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int ecount, input logic [15:0] einstr,
                               input logic eov);
        logic [15:0] t;
        t = einstr;
        check({tag, "_count"}, 32'(Count), 32'(ecount));
        check({tag, "_valid"}, 32'(Valid), 32'(ecount != 0));
        check({tag, "_ready"}, 32'(Ready), 32'(ecount != c_DEPTH));
        check({tag, "_instr"}, 32'(Instruction), 32'(t));
        check({tag, "_opcode"}, 32'(Opcode), 32'(t[15:12]));
        check({tag, "_overrun"}, 32'(Overrun), 32'(eov));
    endtask

    task automatic idle();
        @(negedge Clk);
        Load = 0; Advance = 0; Flush = 0; Data = '0;
    endtask

    initial begin
        // ld, data, adv, fl, count, head, overrun
        vecs.push_back('{1, 16'h1001, 0, 0, 1, 16'h1001, 0});
        vecs.push_back('{1, 16'h2002, 0, 0, 2, 16'h1001, 0});
        vecs.push_back('{1, 16'h3003, 0, 0, 3, 16'h1001, 0});
        vecs.push_back('{0, 16'h0000, 1, 0, 2, 16'h2002, 0});
        vecs.push_back('{0, 16'h0000, 1, 0, 1, 16'h3003, 0});
        vecs.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 16'h0000, 1, 0, 0, 16'h0000, 0});
        vecs.push_back('{1, 16'h5005, 0, 0, 1, 16'h5005, 0});
        vecs.push_back('{1, 16'h6006, 0, 0, 2, 16'h5005, 0});
        vecs.push_back('{1, 16'h7007, 0, 0, 3, 16'h5005, 0});
        vecs.push_back('{1, 16'h8008, 0, 0, 4, 16'h5005, 0});
        vecs.push_back('{1, 16'hBEEF, 1, 0, 3, 16'h6006, 1});
        vecs.push_back('{0, 16'h0000, 0, 0, 3, 16'h6006, 1});
        vecs.push_back('{1, 16'h4444, 0, 1, 0, 16'h0000, 0});
        vecs.push_back('{0, 16'h0000, 0, 0, 0, 16'h0000, 0});
        vecs.push_back('{1, 16'hA001, 0, 0, 1, 16'hA001, 0});
        vecs.push_back('{1, 16'hA002, 0, 0, 2, 16'hA001, 0});
        vecs.push_back('{1, 16'hA003, 1, 0, 2, 16'hA002, 0});
        vecs.push_back('{1, 16'hA004, 1, 0, 2, 16'hA003, 0});
        vecs.push_back('{1, 16'hA005, 1, 0, 2, 16'hA004, 0});
        vecs.push_back('{1, 16'hA006, 1, 0, 2, 16'hA005, 0});
        vecs.push_back('{1, 16'hA007, 1, 0, 2, 16'hA006, 0});
        vecs.push_back('{1, 16'hA008, 1, 0, 2, 16'hA007, 0});
        vecs.push_back('{1, 16'hA009, 0, 0, 3, 16'hA007, 0});
        vecs.push_back('{1, 16'h4444, 0, 1, 0, 16'h0000, 0});
        vecs.push_back('{1, 16'h1234, 0, 0, 1, 16'h1234, 0});

        // Reset takes effect before any clock edge
        #1 Reset = 1'b1;
        #1;
        check_state("reset", 0, 16'h0000, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].data, vecs[i].adv, vecs[i].fl);
            check_state($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].einstr, vecs[i].eov);
            check($sformatf("vec%0d_sb_depth", i), 32'(Count), 32'(sb.size()));
        end

        // Drain, fill past full, then take two out to sit at Count=2 with Overrun set
        step(0, 16'h0000, 1, 0);
        step(1, 16'hC001, 0, 0);
        step(1, 16'hC002, 0, 0);
        step(1, 16'hC003, 0, 0);
        step(1, 16'hC004, 0, 0);
        step(1, 16'hC005, 0, 0);
        check_state("ovf_full", 4, 16'hC001, 1);
        step(0, 16'h0000, 1, 0);
        step(0, 16'h0000, 1, 0);
        check_state("pre_reset", 2, 16'hC003, 1);
        idle();

        // Asynchronous reset mid-cycle, checked before the next rising edge
        #2 Reset = 1'b1;
        #1;
        check_state("async_reset", 0, 16'h0000, 0);
        sb.delete();
        @(negedge Clk);
        Reset = 1'b0;

        step(1, 16'h7777, 0, 0);
        check_state("post_reset_push", 1, 16'h7777, 0);
        step(0, 16'h0000, 1, 0);
        check_state("post_reset_pop", 0, 16'h0000, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_queue
`default_nettype wire
